// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the MEM-stage bus master: funct3 encodings, FSM states, lane width
// and the access legality check.
package mem_bus_master_pkg;

    localparam int STRB_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Unsupported encodings (including unsigned stores) are treated like a misaligned access.
    function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    access_ok = 1'b1;
            F3_H:    access_ok = ~addr_lo[0];
            F3_W:    access_ok = (addr_lo == 2'b00);
            F3_BU:   access_ok = ~we;
            F3_HU:   access_ok = ~we & ~addr_lo[0];
            default: access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit data bus: store strobes/replication and load extract/extend.
module mem_lane_align
    import mem_bus_master_pkg::*;
(
    input  logic              st_we,
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_addr_lo,
    input  logic [31:0]       st_wdata,
    output logic [STRB_W-1:0] st_strb,
    output logic [31:0]       st_wdata_lane,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic [31:0]       ld_rdata,
    output logic [31:0]       ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_strb       = 4'b1111;
        st_wdata_lane = st_wdata;
        if (st_we) begin
            case (st_funct3)
                F3_B: begin
                    st_strb       = 4'b0001 << st_addr_lo;
                    st_wdata_lane = {4{st_wdata[7:0]}};
                end
                F3_H: begin
                    st_strb       = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_wdata_lane = {2{st_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_sel = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        half_sel = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'b0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'b0, half_sel};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// MEM-stage load/store bus master: one valid/ready bus transaction per pipeline request.
// Optional handshake watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              mem_err,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_strb,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t              state;
    logic [2:0]          funct3_q;
    logic [1:0]          addr_lo_q;
    logic                req_ok;
    logic [STRB_W-1:0]   st_strb;
    logic [DATA_W-1:0]   st_wdata_lane;
    logic [DATA_W-1:0]   ld_data;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    assign req_ok = access_ok(mem_we, mem_funct3, mem_addr[1:0]);

    // The stall must begin in the request cycle itself, so IDLE decodes it combinationally.
    assign busy = (state == ST_IDLE) ? (mem_req & req_ok)
                                     : ((state == ST_REQ) || (state == ST_RSP));

    mem_lane_align u_lane (
        .st_we         (mem_we),
        .st_funct3     (mem_funct3),
        .st_addr_lo    (mem_addr[1:0]),
        .st_wdata      (mem_wdata),
        .st_strb       (st_strb),
        .st_wdata_lane (st_wdata_lane),
        .ld_funct3     (funct3_q),
        .ld_addr_lo    (addr_lo_q),
        .ld_rdata      (bus_rdata),
        .ld_data       (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_err   <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_strb  <= '0;
            mem_rdata <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            mem_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req && req_ok) begin
                        state     <= ST_REQ;
                        bus_valid <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= st_wdata_lane;
                        bus_strb  <= st_strb;
                        funct3_q  <= mem_funct3;
                        addr_lo_q <= mem_addr[1:0];
`ifdef BUS_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else if (mem_req) begin
                        mem_err <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_ready) begin
                        state     <= ST_RSP;
                        bus_valid <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt  <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= ST_DONE;
                        bus_valid <= 1'b0;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                ST_RSP: begin
                    // Store acknowledgements complete the transfer but leave the load result alone.
                    if (bus_rvalid) begin
                        state <= ST_DONE;
                        if (!bus_we) mem_rdata <= ld_data;
`ifdef BUS_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= ST_DONE;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed scenarios plus randomized transactions
// checked against a lane/extension model built from plain arithmetic.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_funct3 = 3'b000;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        mem_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_ready = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_rdata = '0;

    mem_bus_master dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .mem_err    (mem_err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_strb   (bus_strb),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (we && f3 > 3'd2) return 1'b0;
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (addr % 2) == 0;
            3'd2:       return (addr % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic we, input logic [2:0] f3, input int off);
        if (!we) return 4'hF;
        case (f3)
            3'd0:    return 4'(1 << off);
            3'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            3'd0:    return (wdata & 32'hFF) * 32'h0101_0101;
            3'd1:    return (wdata & 32'hFFFF) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] rdata,
                                               input int off);
        logic [31:0]        shifted;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        int                 v;
        shifted = rdata >> (8 * off);
        case (f3)
            3'd0: begin sb = shifted[7:0];  v = sb; return v; end
            3'd1: begin sh = shifted[15:0]; v = sh; return v; end
            3'd4: return shifted & 32'hFF;
            3'd5: return shifted & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    // Complete legal transaction with the given slave delays; called just after a clock edge in IDLE.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int ready_dly, input int rsp_dly);
        int busy_cycles = 0;
        int off = int'(addr % 4);
        mem_req = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = addr; mem_wdata = wdata;
        #1;
        checkOutput("busy_in_request_cycle", busy, 1);
        busy_cycles += busy;
        tick();
        checkOutput("bus_addr", bus_addr, addr - (addr % 4));
        checkOutput("bus_we", bus_we, we);
        checkOutput("bus_strb", bus_strb, model_strb(we, f3, off));
        if (we) checkOutput("bus_wdata", bus_wdata, model_wdata(f3, wdata));
        for (int i = 0; i < ready_dly; i++) begin
            checkOutput("bus_valid_waiting", bus_valid, 1);
            busy_cycles += busy;
            tick();
        end
        checkOutput("bus_valid_req", bus_valid, 1);
        busy_cycles += busy;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checkOutput("bus_valid_after_ready", bus_valid, 0);
        for (int i = 0; i < rsp_dly; i++) begin
            busy_cycles += busy;
            tick();
        end
        busy_cycles += busy;
        bus_rvalid = 1'b1; bus_rdata = rdata;
        tick();
        bus_rvalid = 1'b0; bus_rdata = $urandom;
        if (!we) exp_rdata = model_load(f3, rdata, off);
        checkOutput("busy_done", busy, 0);
        checkOutput("mem_rdata", mem_rdata, exp_rdata);
        checkOutput("mem_err_done", mem_err, 0);
        checkOutput("busy_cycle_count", busy_cycles, 3 + ready_dly + rsp_dly);
        tick();
        mem_req = 1'b0;
        #1;
        checkOutput("request_in_done_ignored", bus_valid, 0);
        checkOutput("busy_idle", busy, 0);
    endtask

    task automatic applyIllegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int pulses = 0;
        int valids = 0;
        mem_req = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = addr; mem_wdata = $urandom;
        #1;
        checkOutput("busy_illegal", busy, 0);
        pulses += mem_err;
        tick();
        mem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulses += mem_err;
            valids += bus_valid;
            tick();
        end
        checkOutput("mem_err_single_pulse", pulses, 1);
        checkOutput("bus_valid_never", valids, 0);
        checkOutput("mem_rdata_kept", mem_rdata, exp_rdata);
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  load_codes [5];
        load_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        tick();
        tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_mem_err", mem_err, 0);
        checkOutput("reset_bus_valid", bus_valid, 0);
        checkOutput("reset_bus_addr", bus_addr, 0);
        checkOutput("reset_bus_wdata", bus_wdata, 0);
        checkOutput("reset_bus_strb", bus_strb, 0);
        checkOutput("reset_mem_rdata", mem_rdata, 0);
        rst = 1'b0;
        tick();

        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
        checkOutput("lw_value", exp_rdata, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 0);
        checkOutput("lb_value", mem_rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 1, 0);
        checkOutput("lbu_value", mem_rdata, 32'h00000080);
        applyStimulus(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 2, 1);
        checkOutput("sh_bus_wdata", bus_wdata, 32'hABCDABCD);
        checkOutput("sh_bus_strb", bus_strb, 4'b1100);

        applyIllegal(1'b0, 3'd2, 32'h101);
        applyIllegal(1'b0, 3'd3, 32'h100);
        applyIllegal(1'b1, 3'd6, 32'h104);

        mem_req = 1'b1; mem_we = 1'b0; mem_funct3 = 3'd2; mem_addr = 32'h300;
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_busy", busy, 1);
            checkOutput("stall_bus_valid", bus_valid, 1);
            tick();
        end
        rst = 1'b1; mem_req = 1'b0;
        tick();
        rst = 1'b0;
        exp_rdata = '0;
        checkOutput("midreset_bus_valid", bus_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_mem_rdata", mem_rdata, 0);
        checkOutput("midreset_bus_strb", bus_strb, 0);
        applyStimulus(1'b0, 3'd5, 32'h402, 32'h0, 32'h8001_1234, 0, 0);
        checkOutput("after_reset_lhu", mem_rdata, 32'h0000_8001);

        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : load_codes[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == 3'd2) addr = addr & ~32'h3;
                else if (f3 == 3'd1 || f3 == 3'd5) addr = addr & ~32'h1;
            end
            if (is_legal(we, f3, addr))
                applyStimulus(we, f3, addr, $urandom, $urandom,
                              $urandom_range(0, 3), $urandom_range(0, 3));
            else
                applyIllegal(we, f3, addr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
